npc_fetch_decode_exec: RTL and testbench
========================================

Name: npc_fetch_decode_exec

Overview:
- Single-cycle RV32I front/execute slice of the NPC core: instruction fetch (IFU), decode (IDU) and ALU in one block.
- The PC register, register file and data memory live outside. The parent supplies pc, register read data and memory read data.
- The block returns register-file controls, the write-back value, memory controls, the next PC and a halt flag.
- All outputs are combinational from the current instruction, except the sticky halt register.

Parameters:
None.

Ports:
clk  in  1  clock; rising edge
rst  in  1  synchronous, active-high reset
pc  in  32  current PC (held by parent, reset 0x8000_0000)
imem_addr  out  32  instruction fetch address = pc
imem_rdata  in  32  instruction word at imem_addr, same cycle
inst  out  32  fetched instruction (= imem_rdata)
rs1, rs2, rd  out  5 each  register indices (inst[19:15], [24:20], [11:7]; rs1 forced 0 for LUI)
src1, src2  in  32 each  register file read data for rs1/rs2
reg_wen  out  1  register write enable
reg_wdata  out  32  write-back value
mem_ren, mem_wen  out  1 each  load / store strobe
mem_addr  out  32  src1 + imm
mem_wdata  out  32  src2
mem_len  out  2  0 = byte, 1 = half, 2 = word
mem_rdata  in  32  load data, right-aligned by memory
npc  out  32  next PC
illegal  out  1  unrecognised encoding
halt  out  1  ebreak seen (sticky)

Behaviour:
- imm by format: I, S, B, U, J, sign-extended per RV32I; U = inst[31:12] << 12.
- ALU operand1 = pc for AUIPC/JAL/JALR, else src1.
- ALU operand2 = imm for I/S/U/load/AUIPC, 4 for JAL/JALR, else src2.
- ALU op codes (5-bit, internal):
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - EQ 10, NE 11, GE 12, GEU 13.
  - Compare ops return 0/1.
  - Shifts use operand2[4:0].
  - zero = (result == 0).
- Branches: ALU operands src1/src2; BEQ→EQ, BNE→NE, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU.
  - npc = zero ? pc+4 : pc+imm.
  - Branch target is pc+imm, no alignment check.
- npc selection:
  - JAL: pc+imm.
  - JALR: (src1+imm) & ~1, computed by a separate adder.
  - Branch: as above.
  - All others: pc+4.
- reg_wdata:
  - Loads: extended mem_rdata. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
  - JAL/JALR: pc+4 (ALU result).
  - LUI: imm (0 + imm).
  - Otherwise: alu_result.
- reg_wen = 1 for LUI, AUIPC, JAL, JALR, loads, OP-IMM, OP. Writes with rd = 0 are allowed; the register file ignores them.
- mem_ren = loads; mem_wen = stores; mem_len from funct3[1:0].
- illegal = 1 for unknown opcode/funct3/funct7. When illegal: reg_wen = mem_ren = mem_wen = 0, npc = pc+4.
- ebreak (0x0010_0073):
  - halt asserts combinationally that cycle.
  - halt_q is set on the next rising edge; halt = halt_q | is_ebreak.
  - ebreak itself: reg_wen = 0, npc = pc+4.
- While halt_q = 1: reg_wen and mem_wen are forced 0. npc still computed.
- ecall, fence: treated as nop (npc = pc+4, no writes).
- rst = 1 at a clock edge clears halt_q, with priority over ebreak in the same cycle. No other state.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), pc 0x8000_0000 -> rd 1, reg_wen 1, reg_wdata 0xFFFF_FFFF, npc 0x8000_0004.
- beq with src1 = src2 = 5, imm +8, pc 0x8000_0010 -> npc 0x8000_0018. Then src2 = 6 -> npc 0x8000_0014, reg_wen 0.
- jalr x1,8(x2) with src2-path src1 = 0x8000_0101 -> npc 0x8000_0108, reg_wdata pc+4.
- lb with mem_rdata 0x0000_0080 -> reg_wdata 0xFFFF_FF80, mem_ren 1, mem_len 0. Same data with lbu -> 0x0000_0080.
- sw x2,4(x1) with src1 0x100, src2 0xDEAD_BEEF -> mem_wen 1, mem_addr 0x104, mem_wdata 0xDEAD_BEEF, reg_wen 0.
- ebreak -> halt 1 same cycle, stays 1 after the instruction changes, reg_wen 0 afterwards; rst high one edge -> halt 0. Opcode 0x0000_0000 -> illegal 1, npc pc+4.

Source files
------------

// File: rtl/npc_fetch_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : npc_fetch_decode_exec
// Purpose  : Single-cycle RV32I fetch/decode/ALU slice of the NPC core.
//            Builds the immediate and decodes the instruction. Runs the ALU
//            and selects the write-back value and the next PC. PC, register
//            file and data memory are held by the parent.
// Ports    : clk, rst        - clock and synchronous active-high reset
//            pc              - current PC from the parent
//            imem_addr/rdata - instruction fetch (same-cycle read)
//            inst            - fetched instruction
//            rs1/rs2/rd      - register indices; src1/src2 read data back
//            reg_wen/wdata   - register write-back
//            mem_*           - data memory strobes, address, data, size
//            npc             - next PC
//            illegal         - unrecognised encoding
//            halt            - ebreak seen (sticky until rst)
// Revision : 1.0 - initial release
// ============================================================================
module npc_fetch_decode_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        reg_wen,
  output logic [31:0] reg_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_len,
  input  logic [31:0] mem_rdata,
  output logic [31:0] npc,
  output logic        illegal,
  output logic        halt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_EQ   = 5'd10;
  localparam logic [4:0] ALU_NE   = 5'd11;
  localparam logic [4:0] ALU_GE   = 5'd12;
  localparam logic [4:0] ALU_GEU  = 5'd13;

  typedef enum logic [1:0] {A1_SRC1, A1_PC, A1_ZERO} a1_sel_t;
  typedef enum logic [1:0] {A2_SRC2, A2_IMM, A2_FOUR} a2_sel_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [4:0]  alu_op;
  a1_sel_t     a1_sel;
  a2_sel_t     a2_sel;
  logic        legal, wb_en, is_load, is_store, is_branch, is_jal, is_jalr;
  logic        is_ebreak, halt_q, zero;
  logic [31:0] op1, op2, alu_result, load_data, pc_plus4, pc_plus_imm, jalr_sum;

  assign imem_addr = pc;
  assign inst      = imem_rdata;
  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];
  assign rs1       = (opcode == OPC_LUI) ? 5'd0 : inst[19:15];
  assign rs2       = inst[24:20];
  assign rd        = inst[11:7];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm       = 32'd0;
    alu_op    = ALU_ADD;
    a1_sel    = A1_SRC1;
    a2_sel    = A2_SRC2;
    legal     = 1'b0;
    wb_en     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_ebreak = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; imm = imm_u; a1_sel = A1_ZERO; a2_sel = A2_IMM; wb_en = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; imm = imm_u; a1_sel = A1_PC; a2_sel = A2_IMM; wb_en = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; imm = imm_j; a1_sel = A1_PC; a2_sel = A2_FOUR; wb_en = 1'b1;
        is_jal = 1'b1;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'b000); imm = imm_i; a1_sel = A1_PC; a2_sel = A2_FOUR;
        wb_en = 1'b1; is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        imm = imm_b; is_branch = 1'b1; legal = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_EQ;
          3'b001:  alu_op = ALU_NE;
          3'b100:  alu_op = ALU_SLT;
          3'b101:  alu_op = ALU_GE;
          3'b110:  alu_op = ALU_SLTU;
          3'b111:  alu_op = ALU_GEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        imm = imm_i; a2_sel = A2_IMM; is_load = 1'b1; wb_en = 1'b1;
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OPC_STORE: begin
        imm = imm_s; a2_sel = A2_IMM; is_store = 1'b1;
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_OPIMM: begin
        imm = imm_i; a2_sel = A2_IMM; wb_en = 1'b1; legal = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b001: begin alu_op = ALU_SLL; legal = (funct7 == 7'b0000000); end
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: begin
            alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        wb_en = 1'b1;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin legal = 1'b1; alu_op = ALU_SUB; end
          if (funct3 == 3'b101) begin legal = 1'b1; alu_op = ALU_SRA; end
        end
      end
      OPC_FENCE:  legal = (funct3 == 3'b000);
      OPC_SYSTEM: begin
        legal     = (inst == INST_ECALL) || (inst == INST_EBREAK);
        is_ebreak = (inst == INST_EBREAK);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (a1_sel)
      A1_PC:   op1 = pc;
      A1_ZERO: op1 = 32'd0;
      default: op1 = src1;
    endcase
    case (a2_sel)
      A2_IMM:  op2 = imm;
      A2_FOUR: op2 = 32'd4;
      default: op2 = src2;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_result = op1 + op2;
      ALU_SUB:  alu_result = op1 - op2;
      ALU_SLL:  alu_result = op1 << op2[4:0];
      ALU_SLT:  alu_result = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_result = {31'd0, op1 < op2};
      ALU_XOR:  alu_result = op1 ^ op2;
      ALU_SRL:  alu_result = op1 >> op2[4:0];
      ALU_SRA:  alu_result = 32'($signed(op1) >>> op2[4:0]);
      ALU_OR:   alu_result = op1 | op2;
      ALU_AND:  alu_result = op1 & op2;
      ALU_EQ:   alu_result = {31'd0, op1 == op2};
      ALU_NE:   alu_result = {31'd0, op1 != op2};
      ALU_GE:   alu_result = {31'd0, $signed(op1) >= $signed(op2)};
      ALU_GEU:  alu_result = {31'd0, op1 >= op2};
      default:  alu_result = 32'd0;
    endcase
  end

  assign zero        = (alu_result == 32'd0);
  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_imm = pc + imm;
  // JALR uses its own adder because the ALU is busy producing the link value.
  assign jalr_sum    = src1 + imm;

  always_comb begin
    if (!legal)         npc = pc_plus4;
    else if (is_jal)    npc = pc_plus_imm;
    else if (is_jalr)   npc = {jalr_sum[31:1], 1'b0};
    // Branch ALU ops return 1 when the condition holds, so zero means fall through.
    else if (is_branch) npc = zero ? pc_plus4 : pc_plus_imm;
    else                npc = pc_plus4;
  end

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_data = {24'd0, mem_rdata[7:0]};
      3'b101:  load_data = {16'd0, mem_rdata[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  assign reg_wdata = is_load ? load_data : alu_result;
  assign reg_wen   = legal & wb_en & ~halt_q;
  assign mem_ren   = legal & is_load;
  assign mem_wen   = legal & is_store & ~halt_q;
  assign mem_addr  = src1 + imm;
  assign mem_wdata = src2;
  assign mem_len   = funct3[1:0];
  assign illegal   = ~legal;
  assign halt      = halt_q | is_ebreak;

  always_ff @(posedge clk) begin
    if (rst)            halt_q <= 1'b0;
    else if (is_ebreak) halt_q <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_npc_fetch_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_fetch_decode_exec
// Purpose  : Directed self-checking bench for npc_fetch_decode_exec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npc_fetch_decode_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, imem_addr, imem_rdata, inst;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] src1, src2, reg_wdata, mem_addr, mem_wdata, mem_rdata, npc;
  logic        reg_wen, mem_ren, mem_wen, illegal, halt;
  logic [1:0]  mem_len;

  int checks = 0;
  int errors = 0;

  npc_fetch_decode_exec dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .rs1(rs1), .rs2(rs2), .rd(rd), .src1(src1), .src2(src2),
    .reg_wen(reg_wen), .reg_wdata(reg_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_rdata(mem_rdata), .npc(npc), .illegal(illegal), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one instruction at the falling edge and settle before checking.
  task automatic step(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] md);
    @(negedge clk);
    imem_rdata = i; pc = p; src1 = s1; src2 = s2; mem_rdata = md;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_rdata = 32'h0000_0013; pc = 32'h8000_0000;
    src1 = 0; src2 = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("nop_illegal", {31'd0, illegal}, 32'd0);

    // addi x1,x0,-1
    step(32'hFFF0_0093, 32'h8000_0000, 0, 0, 0);
    check("addi_imem_addr", imem_addr, 32'h8000_0000);
    check("addi_inst", inst, 32'hFFF0_0093);
    check("addi_rd", {27'd0, rd}, 32'd1);
    check("addi_wen", {31'd0, reg_wen}, 32'd1);
    check("addi_wdata", reg_wdata, 32'hFFFF_FFFF);
    check("addi_npc", npc, 32'h8000_0004);

    // beq x1,x2,+8 taken, then not taken
    step(32'h0020_8463, 32'h8000_0010, 5, 5, 0);
    check("beq_taken_npc", npc, 32'h8000_0018);
    step(32'h0020_8463, 32'h8000_0010, 5, 6, 0);
    check("beq_nt_npc", npc, 32'h8000_0014);
    check("beq_wen", {31'd0, reg_wen}, 32'd0);

    // blt signed -1 < 1 taken; bltu 0xFFFFFFFF < 1 not taken
    step(32'h0020_C463, 32'h8000_0020, 32'hFFFF_FFFF, 1, 0);
    check("blt_npc", npc, 32'h8000_0028);
    step(32'h0020_E463, 32'h8000_0020, 32'hFFFF_FFFF, 1, 0);
    check("bltu_npc", npc, 32'h8000_0024);

    // jalr x1,8(x2)
    step(32'h0081_00E7, 32'h8000_0040, 32'h8000_0101, 0, 0);
    check("jalr_npc", npc, 32'h8000_0108);
    check("jalr_wdata", reg_wdata, 32'h8000_0044);
    check("jalr_wen", {31'd0, reg_wen}, 32'd1);

    // jal x1,+16
    step(32'h0100_00EF, 32'h8000_0050, 0, 0, 0);
    check("jal_npc", npc, 32'h8000_0060);
    check("jal_wdata", reg_wdata, 32'h8000_0054);

    // lui x5,0x12345 with garbage on src1 (rs1 forced 0)
    step(32'h1234_52B7, 32'h8000_0060, 32'h5555_5555, 0, 0);
    check("lui_wdata", reg_wdata, 32'h1234_5000);
    check("lui_rs1", {27'd0, rs1}, 32'd0);

    // sub x3,x1,x2
    step(32'h4020_81B3, 32'h8000_0064, 10, 3, 0);
    check("sub_wdata", reg_wdata, 32'd7);

    // lb / lbu x3,0(x1)
    step(32'h0000_8183, 32'h8000_0070, 32'h200, 0, 32'h0000_0080);
    check("lb_wdata", reg_wdata, 32'hFFFF_FF80);
    check("lb_ren", {31'd0, mem_ren}, 32'd1);
    check("lb_len", {30'd0, mem_len}, 32'd0);
    check("lb_addr", mem_addr, 32'h200);
    step(32'h0000_C183, 32'h8000_0074, 32'h200, 0, 32'h0000_0080);
    check("lbu_wdata", reg_wdata, 32'h0000_0080);

    // sw x2,4(x1)
    step(32'h0020_A223, 32'h8000_0080, 32'h100, 32'hDEAD_BEEF, 0);
    check("sw_wen", {31'd0, mem_wen}, 32'd1);
    check("sw_addr", mem_addr, 32'h104);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw_len", {30'd0, mem_len}, 32'd2);
    check("sw_reg_wen", {31'd0, reg_wen}, 32'd0);

    // illegal all-zero word
    step(32'h0000_0000, 32'h8000_0090, 0, 0, 0);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_npc", npc, 32'h8000_0094);
    check("ill_wen", {31'd0, reg_wen}, 32'd0);

    // ebreak: combinational then sticky
    step(32'h0010_0073, 32'h8000_00A0, 0, 0, 0);
    check("ebreak_halt", {31'd0, halt}, 32'd1);
    check("ebreak_wen", {31'd0, reg_wen}, 32'd0);
    check("ebreak_npc", npc, 32'h8000_00A4);
    step(32'hFFF0_0093, 32'h8000_00A4, 0, 0, 0);
    check("halted_sticky", {31'd0, halt}, 32'd1);
    check("halted_wen", {31'd0, reg_wen}, 32'd0);
    check("halted_npc", npc, 32'h8000_00A8);
    step(32'h0020_A223, 32'h8000_00A8, 32'h100, 32'h1, 0);
    check("halted_mem_wen", {31'd0, mem_wen}, 32'd0);

    // reset with ebreak present: reset wins
    step(32'h0010_0073, 32'h8000_00AC, 0, 0, 0);
    rst = 1'b1;
    step(32'hFFF0_0093, 32'h8000_00B0, 0, 0, 0);
    rst = 1'b0;
    step(32'hFFF0_0093, 32'h8000_00B0, 0, 0, 0);
    check("post_rst_halt", {31'd0, halt}, 32'd0);
    check("post_rst_wen", {31'd0, reg_wen}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
